// File: rtl/knn_selector.sv
// K-nearest-neighbour selector: keeps the K closest samples in a sorted
// register list, then majority-votes their class types.
module knn_selector #(
  parameter int W      = 16,
  parameter int TYPE_W = 2,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      distance,
  input  logic [TYPE_W-1:0] data_type,
  input  logic              done,
  input  logic              last,
  output logic              busy,
  output logic [TYPE_W-1:0] result_type,
  output logic [W-1:0]      min_distance,
  output logic [3:0]        neighbour_count,
  output logic              result_valid
);

  localparam int NT = 2 ** TYPE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VOTE,
    S_SELECT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [W-1:0]      r_dist [K];
  logic [TYPE_W-1:0] r_type [K];
  logic [K-1:0]      r_valid;
  logic [3:0]        r_cnt [NT];
  logic [3:0]        r_vidx;

  logic              r_busy;
  logic [TYPE_W-1:0] r_res;
  logic [W-1:0]      r_min;
  logic [3:0]        r_nc;
  logic              r_rv;

  logic [K-1:0]      w_lt;
  logic [K-1:0]      w_sh;
  logic [K-1:0]      w_pv;
  logic [W-1:0]      w_pd [K];
  logic [TYPE_W-1:0] w_pt [K];
  logic [TYPE_W-1:0] w_win;
  logic [3:0]        w_best;
  logic [3:0]        w_nvalid;

  // Rank i takes the new sample when it is the first slot that is empty
  // or strictly farther; every rank after it takes its predecessor.
  always_comb begin
    w_lt    = '0;
    w_sh    = '0;
    w_pv    = '0;
    w_pd[0] = '0;
    w_pt[0] = '0;
    for (int i = 0; i < K; i++) begin
      w_lt[i] = !r_valid[i] || (distance < r_dist[i]);
    end
    for (int i = 1; i < K; i++) begin
      w_sh[i] = w_lt[i-1];
      w_pv[i] = r_valid[i-1];
      w_pd[i] = r_dist[i-1];
      w_pt[i] = r_type[i-1];
    end
  end

  // Scanning ranks nearest-first with a strict compare breaks ties
  // in favour of the type owning the nearest entry.
  always_comb begin
    w_win    = '0;
    w_best   = '0;
    w_nvalid = '0;
    for (int i = 0; i < K; i++) begin
      if (r_valid[i] && (r_cnt[r_type[i]] > w_best)) begin
        w_best = r_cnt[r_type[i]];
        w_win  = r_type[i];
      end
      w_nvalid = w_nvalid + 4'(r_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_vidx  <= '0;
      r_busy  <= 1'b0;
      r_res   <= '0;
      r_min   <= {1'b0, {(W-1){1'b1}}};
      r_nc    <= '0;
      r_rv    <= 1'b0;
      for (int i = 0; i < K; i++) begin
        r_dist[i] <= '0;
        r_type[i] <= '0;
      end
      for (int t = 0; t < NT; t++) begin
        r_cnt[t] <= '0;
      end
    end else begin
      r_rv <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_valid <= '0;
            for (int t = 0; t < NT; t++) begin
              r_cnt[t] <= '0;
            end
            r_state <= S_COLLECT;
            r_busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (start) begin
            r_valid <= '0;
          end else if (done) begin
            for (int i = 0; i < K; i++) begin
              if (w_lt[i] && !w_sh[i]) begin
                r_dist[i]  <= distance;
                r_type[i]  <= data_type;
                r_valid[i] <= 1'b1;
              end else if (w_sh[i]) begin
                r_dist[i]  <= w_pd[i];
                r_type[i]  <= w_pt[i];
                r_valid[i] <= w_pv[i];
              end
            end
            if (last) begin
              r_vidx  <= '0;
              r_state <= S_VOTE;
            end
          end
        end
        S_VOTE: begin
          for (int i = 0; i < K; i++) begin
            if ((4'(i) == r_vidx) && r_valid[i]) begin
              r_cnt[r_type[i]] <= r_cnt[r_type[i]] + 4'd1;
            end
          end
          if (r_vidx == 4'(K - 1)) begin
            r_state <= S_SELECT;
          end else begin
            r_vidx <= r_vidx + 4'd1;
          end
        end
        S_SELECT: begin
          r_res   <= w_win;
          r_min   <= r_dist[0];
          r_nc    <= w_nvalid;
          r_rv    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign result_type     = r_res;
  assign min_distance    = r_min;
  assign neighbour_count = r_nc;
  assign result_valid    = r_rv;

endmodule
